// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, req/ack fetch from instruction memory, valid/ready hand-off to decode.
// Optional FETCH_STALL_CNT_EN build enables the memory-wait counter on stall_cnt.
module instr_fetch_unit #(
    parameter int              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [31:0]       instr,
    output logic [3:0]        opCode,
    output logic [3:0]        fCode,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              halt,
    output logic [15:0]       stall_cnt,
    output logic [1:0]        dbgState
);

    // Decode handshake: an instruction transfers on any rising edge where
    // id_valid and id_ready are both 1; id_valid holds until that edge.
    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    localparam logic [ADDR_W-1:0] FOUR      = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MSK = ~ADDR_W'(3);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pcNext;

    assign pcNext    = pc + FOUR;
    assign imem_addr = pc;
    assign dbgState  = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_REQ;
            pc       <= RESET_PC;
            imem_req <= 1'b0;
            id_valid <= 1'b0;
            instr    <= '0;
            opCode   <= '0;
            fCode    <= '0;
            pc_out   <= '0;
            pc_plus4 <= FOUR;
        end else if (redirect && state != S_HALT) begin
            // Flush: the request slot goes idle for a cycle so any ack for the
            // abandoned fetch lands while imem_req=0 and is dropped.
            pc       <= redirect_target & ALIGN_MSK;
            id_valid <= 1'b0;
            imem_req <= 1'b0;
            state    <= S_REQ;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req && imem_ack) begin
                        instr    <= imem_rdata;
                        opCode   <= imem_rdata[31:28];
                        fCode    <= imem_rdata[3:0];
                        pc_out   <= pc;
                        pc_plus4 <= pcNext;
                        pc       <= pcNext;
                        id_valid <= 1'b1;
                        imem_req <= 1'b0;
                        state    <= S_HOLD;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (id_valid && id_ready) begin
                        id_valid <= 1'b0;
                        if (halt) begin
                            state <= S_HALT;
                        end else begin
                            state    <= S_REQ;
                            imem_req <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    imem_req <= 1'b0;
                    id_valid <= 1'b0;
                end
                default: begin
                    state    <= S_REQ;
                    imem_req <= 1'b0;
                    id_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_STALL_CNT_EN
    // Counts cycles the memory keeps an issued request waiting; saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (state == S_REQ && imem_req && !imem_ack && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: tasks drive memory/decode, a negedge monitor
// pops the expected queue on every decode handshake.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;

    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [31:0]   imem_rdata = '0;
    logic          id_valid;
    logic          id_ready = 1'b0;
    logic [31:0]   instr;
    logic [3:0]    opCode;
    logic [3:0]    fCode;
    logic [AW-1:0] pc_out;
    logic [AW-1:0] pc_plus4;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_target = '0;
    logic          halt = 1'b0;
    logic [15:0]   stall_cnt;
    logic [1:0]    dbgState;

    logic          w_imem_req;
    logic [AW-1:0] w_imem_addr;
    logic          w_imem_ack = 1'b0;
    logic [31:0]   w_imem_rdata = '0;
    logic          w_id_valid;
    logic          w_id_ready = 1'b0;
    logic [31:0]   w_instr;
    logic [3:0]    w_opCode;
    logic [3:0]    w_fCode;
    logic [AW-1:0] w_pc_out;
    logic [AW-1:0] w_pc_plus4;
    logic [15:0]   w_stall_cnt;
    logic [1:0]    w_dbgState;

    int            total = 0;
    int            bad = 0;
    int            expStall = 0;
    logic [AW-1:0] expAddr = '0;
    logic [63:0]   exp_q[$];
    logic [63:0]   monExp;

    instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_ready(id_ready), .instr(instr), .opCode(opCode), .fCode(fCode),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .redirect(redirect), .redirect_target(redirect_target),
        .halt(halt), .stall_cnt(stall_cnt), .dbgState(dbgState)
    );

    instr_fetch_unit #(.ADDR_W(AW), .RESET_PC(32'hFFFF_FFFC)) dutWrap (
        .clk(clk), .rst(rst),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(w_imem_ack), .imem_rdata(w_imem_rdata),
        .id_valid(w_id_valid), .id_ready(w_id_ready), .instr(w_instr), .opCode(w_opCode), .fCode(w_fCode),
        .pc_out(w_pc_out), .pc_plus4(w_pc_plus4), .redirect(1'b0), .redirect_target(32'h0),
        .halt(1'b0), .stall_cnt(w_stall_cnt), .dbgState(w_dbgState)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endfunction

    function automatic int stallRef();
`ifdef FETCH_STALL_CNT_EN
        return expStall;
`else
        return 0;
`endif
    endfunction

    // monitor: every decode handshake must match the oldest expected fetch
    always @(negedge clk) begin
        if (rst && id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", {32'h0, instr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                monExp = exp_q.pop_front();
                chk("out_instr", {32'h0, instr}, {32'h0, monExp[31:0]});
                chk("out_pc", {32'h0, pc_out}, {32'h0, monExp[63:32]});
                chk("out_pc_plus4", {32'h0, pc_plus4}, {32'h0, monExp[63:32] + 32'd4});
                chk("out_fields", {56'h0, opCode, fCode}, {56'h0, monExp[31:28], monExp[3:0]});
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        exp_q.delete();
        expStall = 0;
        expAddr = '0;
        step();
        step();
        chk("rst_req_valid", {62'h0, imem_req, id_valid}, 64'h0);
        chk("rst_instr", {32'h0, instr}, 64'h0);
        chk("rst_fields", {56'h0, opCode, fCode}, 64'h0);
        chk("rst_pc_out", {32'h0, pc_out}, 64'h0);
        chk("rst_pc_plus4", {32'h0, pc_plus4}, 64'h4);
        chk("rst_stall", {48'h0, stall_cnt}, 64'h0);
        chk("rst_addr_state", {30'h0, dbgState, imem_addr}, 64'h0);
        rst = 1'b1;
        step();
        chk("req_after_rst", {63'h0, imem_req}, 64'h1);
    endtask

    task automatic wait_req();
        int n = 0;
        while (!imem_req && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", {63'h0, imem_req}, 64'h1);
    endtask

    task automatic fetch_one(input int dly, input logic [31:0] word, input int hold, input logic h);
        wait_req();
        chk("fetch_addr", {32'h0, imem_addr}, {32'h0, expAddr});
        for (int i = 0; i < dly; i++) begin
            step();
            chk("addr_held", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, expAddr});
        end
        imem_ack = 1'b1;
        imem_rdata = word;
        exp_q.push_back({expAddr, word});
        step();
        imem_ack = 1'b0;
        imem_rdata = '0;
        expStall += dly;
        chk("valid_after_ack", {62'h0, id_valid, imem_req}, 64'h2);
        chk("stall_cnt", {48'h0, stall_cnt}, 64'(stallRef()));
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_ctrl", {62'h0, id_valid, imem_req}, 64'h2);
            chk("hold_data", {instr, pc_out}, {word, expAddr});
        end
        id_ready = 1'b1;
        halt = h;
        step();
        id_ready = 1'b0;
        halt = 1'b0;
        chk("req_after_hs", {62'h0, id_valid, imem_req}, {62'h0, 1'b0, !h});
        expAddr += 32'd4;
    endtask

    // stimulus
    initial begin
        do_reset();

        // back-to-back fetches, fields split out
        fetch_one(0, 32'h1000_000A, 0, 1'b0);
        fetch_one(0, 32'h2000_0005, 0, 1'b0);
        chk("third_addr", {32'h0, imem_addr}, 64'h8);

        // decode back-pressure
        fetch_one(0, 32'h4000_0003, 5, 1'b0);

        // slow memory
        do_reset();
        fetch_one(3, 32'h5000_000C, 0, 1'b0);

        // redirect racing an ack, then a stale ack for the flushed request
        wait_req();
        chk("pre_redirect_addr", {32'h0, imem_addr}, 64'h4);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        redirect = 1'b1;
        redirect_target = 32'h0000_0103;
        step();
        redirect = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        chk("redirect_gap", {62'h0, id_valid, imem_req}, 64'h0);
        step();
        imem_ack = 1'b0;
        imem_rdata = '0;
        chk("stale_ack_dropped", {31'h0, id_valid, imem_req, imem_addr}, {31'h0, 2'b01, 32'h0000_0100});
        expAddr = 32'h0000_0100;
        fetch_one(0, 32'h3000_0007, 0, 1'b0);

        // halt on handshake, redirect and ack afterwards ignored
        fetch_one(0, 32'h6000_0009, 0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                redirect = 1'b1;
                redirect_target = 32'h0000_0200;
                imem_ack = 1'b1;
            end
            step();
            redirect = 1'b0;
            imem_ack = 1'b0;
            chk("halted", {60'h0, dbgState, id_valid, imem_req}, {60'h0, 2'd2, 2'b00});
        end
        chk("halt_pc_kept", {32'h0, imem_addr}, {32'h0, expAddr});

        // asynchronous reset leaves halt and restores the reset PC
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_halt", {31'h0, imem_req, imem_addr}, 64'h0);
        do_reset();

        // asynchronous reset mid-fetch drops the request at once
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_req", {63'h0, imem_req}, 64'h0);
        do_reset();

        // PC wrap at the top of the address space
        chk("wrap_first_addr", {31'h0, w_imem_req, w_imem_addr}, {31'h0, 1'b1, 32'hFFFF_FFFC});
        w_imem_ack = 1'b1;
        w_imem_rdata = 32'h7000_0001;
        step();
        w_imem_ack = 1'b0;
        chk("wrap_pc_out", {w_pc_out, w_pc_plus4}, {32'hFFFF_FFFC, 32'h0});
        chk("wrap_valid", {32'h0, w_instr}, {32'h0, 32'h7000_0001});
        w_id_ready = 1'b1;
        step();
        w_id_ready = 1'b0;
        chk("wrap_second_addr", {31'h0, w_imem_req, w_imem_addr}, {31'h0, 1'b1, 32'h0});

        step();
        chk("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
